// File: rtl/gated_bus_trace_if.sv
// Bus-side signal bundle for gated_bus_trace: source gates/data, bus result and trace reader port.
// Parity signals exist only when BUS_PARITY_EN is defined.
interface gated_bus_trace_if #(
  parameter int DATA_W      = 16,
  parameter int N_SRC       = 4,
  parameter int TRACE_DEPTH = 8
);
  localparam int SRC_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(TRACE_DEPTH) + 1;

  logic [N_SRC-1:0]        Gate;
  logic [N_SRC*DATA_W-1:0] Src_Data;
  logic                    Capture;
  logic                    Clear_Err;
  logic [DATA_W-1:0]       BUS;
  logic                    Bus_Valid;
  logic                    Collision;
  logic [7:0]              Err_Count;
  logic                    Trace_Valid;
  logic                    Trace_Ready;
  logic [DATA_W-1:0]       Trace_Data;
  logic [SRC_W-1:0]        Trace_Src;
  logic [CNT_W-1:0]        Trace_Count;
  logic                    Trace_Overflow;
`ifdef BUS_PARITY_EN
  logic                    Bus_Parity;
  logic                    Trace_Parity;
`endif

  modport master (
    output Gate, Src_Data, Capture, Clear_Err, Trace_Ready,
    input  BUS, Bus_Valid, Collision, Err_Count, Trace_Valid, Trace_Data,
           Trace_Src, Trace_Count, Trace_Overflow
`ifdef BUS_PARITY_EN
    , input Bus_Parity, Trace_Parity
`endif
  );

  modport slave (
    input  Gate, Src_Data, Capture, Clear_Err, Trace_Ready,
    output BUS, Bus_Valid, Collision, Err_Count, Trace_Valid, Trace_Data,
           Trace_Src, Trace_Count, Trace_Overflow
`ifdef BUS_PARITY_EN
    , output Bus_Parity, Trace_Parity
`endif
  );
endinterface

// File: rtl/gated_bus_trace.sv
// Gated N-source bus with last-value hold, collision counting and a FWFT trace FIFO.
// Optional BUS_PARITY_EN adds bus parity and a stored parity bit per trace entry.
module gated_bus_trace #(
  parameter int DATA_W      = 16,
  parameter int N_SRC       = 4,
  parameter int TRACE_DEPTH = 8
) (
  input logic              Clk,
  input logic              Reset,
  gated_bus_trace_if.slave bus_if
);
  localparam int SRC_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(TRACE_DEPTH) + 1;
  localparam int PTR_W = $clog2(TRACE_DEPTH);
`ifdef BUS_PARITY_EN
  localparam int ENTRY_W = DATA_W + SRC_W + 1;
`else
  localparam int ENTRY_W = DATA_W + SRC_W;
`endif
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TRACE_DEPTH);
  localparam logic [7:0]       ERR_MAX  = 8'hFF;

  logic [DATA_W-1:0] sel_data, bus;
  logic [SRC_W-1:0]  sel_idx;
  logic              any_gate, multi_gate, bus_valid, collision;

  logic [DATA_W-1:0] hold_q, hold_d;
  logic [7:0]        err_q, err_d;
  logic              ovf_q, ovf_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ENTRY_W-1:0] mem [TRACE_DEPTH];
  logic [ENTRY_W-1:0] entry, head;
  logic               trace_valid, fifo_full, push_req, push, pop, drop;

  // Walk from the top so the lowest asserted index wins on collision.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    sel_idx  = '0;
    sel_data = '0;
    any_gate = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (bus_if.Gate[i]) begin
        sel_idx  = SRC_W'(i);
        sel_data = bus_if.Src_Data[i*DATA_W +: DATA_W];
        any_gate = 1'b1;
      end
    end
  end

  assign multi_gate = |(bus_if.Gate & (bus_if.Gate - N_SRC'(1)));
  assign bus_valid  = any_gate & ~multi_gate;
  assign collision  = multi_gate;
  assign bus        = any_gate ? sel_data : hold_q;

  assign trace_valid = (cnt_q != '0);
  assign fifo_full   = (cnt_q == FULL_CNT);
  assign push_req    = bus_if.Capture & bus_valid;
  assign pop         = trace_valid & bus_if.Trace_Ready;
  assign push        = push_req & (~fifo_full | pop);
  assign drop        = push_req & fifo_full & ~pop;

`ifdef BUS_PARITY_EN
  assign entry = {^bus, sel_idx, bus};
`else
  assign entry = {sel_idx, bus};
`endif
  assign head = mem[rd_ptr_q];

  always_comb begin
    hold_d   = bus_valid ? bus : hold_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);

    // Clear outranks both the collision increment and a same-cycle drop.
    err_d = err_q;
    ovf_d = ovf_q;
    if (bus_if.Clear_Err) begin
      err_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (collision && err_q != ERR_MAX) err_d = err_q + 8'd1;
      if (drop)                          ovf_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      hold_q   <= '0;
      err_q    <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      hold_q   <= hold_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define which entries are live.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr_q] <= entry;
  end

  assign bus_if.BUS            = bus;
  assign bus_if.Bus_Valid      = bus_valid;
  assign bus_if.Collision      = collision;
  assign bus_if.Err_Count      = err_q;
  assign bus_if.Trace_Valid    = trace_valid;
  assign bus_if.Trace_Data     = trace_valid ? head[DATA_W-1:0] : '0;
  assign bus_if.Trace_Src      = trace_valid ? head[DATA_W +: SRC_W] : '0;
  assign bus_if.Trace_Count    = cnt_q;
  assign bus_if.Trace_Overflow = ovf_q;
`ifdef BUS_PARITY_EN
  assign bus_if.Bus_Parity     = ^bus;
  assign bus_if.Trace_Parity   = trace_valid & head[ENTRY_W-1];
`endif
endmodule
